ks_ram_responder: RTL

- Memory-side responder for the K&S processor RAM port. It serves the data_path's ram_addr/data_out/data_in interface.
- Holds a 32 x 16-bit word array. Reads and writes complete after programmable latencies.
- A side load port lets the bench or boot logic preload programs while the CPU is idle.
- Sits between data_path/control_unit and the top level. It replaces an ideal zero-latency RAM.

---
 rtl/k_and_s_pkg.sv | 21 ++
 rtl/ks_ram_array.sv | 40 ++++
 rtl/ks_ram_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor memory subsystem.
package k_and_s_pkg;

   typedef enum logic [1:0] {
      MEM_CLEAR,
      MEM_IDLE,
      MEM_WAIT,
      MEM_RESP
   } mem_state_type;

   localparam int RAM_ADDR_W  = 5;
   localparam int RAM_DATA_W  = 16;
   localparam int MAX_MEM_LAT = 7;
   localparam int LAT_CNT_W   = $clog2(MAX_MEM_LAT + 1);

   // WAIT counts down to zero, so a latency of L is loaded as L-1.
   function automatic logic [LAT_CNT_W-1:0] lat_init(input int lat);
      return LAT_CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/ks_ram_array.sv
// Single-write-port register array with a registered read port.
module ks_ram_array
   import k_and_s_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data is held until the next read, so writes never disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ks_ram_responder.sv
// RAM-port responder for the K&S processor: clear-on-reset, programmable
// read/write latency, and a side preload port that yields to the CPU.
module ks_ram_responder
   import k_and_s_pkg::*;
#(
   parameter int ADDR_W    = RAM_ADDR_W,
   parameter int DATA_W    = RAM_DATA_W,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_req,
   input  logic              ram_write,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_wdata,
   output logic [DATA_W-1:0] ram_rdata,
   output logic              ram_ready,
   output logic              ram_busy,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready
);

   if (READ_LAT < 1 || READ_LAT > MAX_MEM_LAT ||
       WRITE_LAT < 1 || WRITE_LAT > MAX_MEM_LAT) begin : g_bad_lat
      $error("ks_ram_responder: READ_LAT/WRITE_LAT must be in 1..%0d", MAX_MEM_LAT);
   end

   mem_state_type state_q, state_d;

   logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
   logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic                 wr_q, wr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              ready_raw;
   logic              load_ack_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MEM_CLEAR;
         clr_cnt_q <= '0;
         lat_cnt_q <= '0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         lat_cnt_q <= lat_cnt_d;
         wr_q      <= wr_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_waddr    = addr_q;
      mem_wdata    = wdata_q;
      ready_raw    = 1'b0;
      load_ack_raw = 1'b0;
      ram_busy     = 1'b1;

      unique case (state_q)
         MEM_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = MEM_IDLE;
            end
         end
         MEM_IDLE: begin
            ram_busy = 1'b0;
            if (ram_req) begin
               addr_d    = ram_addr;
               wr_d      = ram_write;
               wdata_d   = ram_wdata;
               lat_cnt_d = ram_write ? lat_init(WRITE_LAT) : lat_init(READ_LAT);
               state_d   = MEM_WAIT;
            end else if (load_valid) begin
               mem_we       = 1'b1;
               mem_waddr    = load_addr;
               mem_wdata    = load_data;
               load_ack_raw = 1'b1;
            end
         end
         MEM_WAIT: begin
            // The array access happens on the edge that enters RESP.
            if (lat_cnt_q == '0) begin
               mem_we  = wr_q;
               mem_re  = ~wr_q;
               state_d = MEM_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         MEM_RESP: begin
            ready_raw = 1'b1;
            state_d   = MEM_IDLE;
         end
         default: begin
            state_d = MEM_CLEAR;
         end
      endcase
   end

   // A reset in the same cycle aborts whatever the FSM was about to commit.
   assign ram_ready  = ready_raw & ~rst;
   assign load_ready = load_ack_raw & ~rst;

   ks_ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_we & ~rst),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (mem_re & ~rst),
      .raddr_i (addr_q),
      .rdata_o (ram_rdata)
   );

endmodule
